// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Digit-serial multi-cycle adder. Adds two WIDTH-bit operands plus a carry-in,
// DIGIT bits per clock, through a registered carry. An operation takes
// N = WIDTH/DIGIT clock edges after the start is accepted. The result is held
// on sum/co until the next operation completes.
//
// Parameters:
//   WIDTH  operand and sum width in bits (must be an exact multiple of DIGIT)
//   DIGIT  bits added per clock (1 = bit-serial, WIDTH = single step)
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous reset, active-high (priority over start)
//   start  request a new addition; sampled only when not busy
//   A, B   operands, captured on an accepted start
//   cin    carry-in, captured on an accepted start
//   sub    (SERIAL_ADDER_SUB_EN only) 1 = compute A - B as A + ~B + 1
//   busy   high while an addition is in progress
//   done   one-cycle pulse when sum/co are updated
//   sum    registered result, low WIDTH bits of A + B + cin
//   co     registered carry-out (bit WIDTH of the exact sum)
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, adds the sub input. With sub=1 the carry register is loaded
//   with 1 and B is inverted at capture, so co=1 means "no borrow" (A >= B).
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    count;

    logic [DIGIT:0]   digit_sum;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    // One digit step: add the low digits plus carry, then shift the new digit
    // in at the MSB end of the result. Zero-extending before the shift keeps
    // the expressions legal when DIGIT == WIDTH.
    always_comb begin
        digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry};
        res_next  = WIDTH'({digit_sum[DIGIT-1:0], res_sh} >> DIGIT);
        a_next    = WIDTH'({{DIGIT{1'b0}}, a_sh} >> DIGIT);
        b_next    = WIDTH'({{DIGIT{1'b0}}, b_sh} >> DIGIT);
    end

    // Operand conditioning at capture time.
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_load     = sub ? ~B : B;
        carry_load = sub ? 1'b1 : cin;
`else
        b_load     = B;
        carry_load = cin;
`endif
    end

    // NOTE: all state, including the datapath shift registers, uses
    // non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            co     <= 1'b0;
            carry  <= 1'b0;
            count  <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
        end else begin
            // NOTE: done defaults low every cycle so it can only ever be a
            // single-cycle pulse raised on the completing edge.
            done <= 1'b0;
            case (state)
                // DONE is indistinguishable from IDLE apart from the done
                // pulse, so back-to-back starts are accepted there.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_next;
                    b_sh   <= b_next;
                    res_sh <= res_next;
                    carry  <= digit_sum[DIGIT];
                    count  <= count + CW'(1);
                    if (count == LAST_STEP) begin
                        sum   <= res_next;
                        co    <= digit_sum[DIGIT];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Scoreboard bench for serial_adder. Two instances share the operand inputs:
// dut1 (WIDTH=8, DIGIT=1, 8 steps) and dut4 (WIDTH=8, DIGIT=4, 2 steps), each
// with its own start. The driver pushes the expected {co,sum} and the issue
// cycle into a per-instance queue; a monitor per instance pops and compares on
// every done pulse, including the start-to-done latency. Build with
// +define+SERIAL_ADDER_SUB_EN to also exercise the subtract option.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       start1 = 1'b0;
    logic       start4 = 1'b0;
    logic       cin_in = 1'b0;
    logic       sub_in = 1'b0;
    logic [7:0] a_in   = 8'h00;
    logic [7:0] b_in   = 8'h00;

    logic       busy1, done1, co1;
    logic       busy4, done4, co4;
    logic [7:0] sum1, sum4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] sum;
        logic       co;
        int         issue;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    logic [7:0] held1 = 8'h00;
    logic [7:0] held4 = 8'h00;
    logic       prev1 = 1'b0;
    logic       prev4 = 1'b0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .A     (a_in),
        .B     (b_in),
        .cin   (cin_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_in),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .co    (co1)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .A     (a_in),
        .B     (b_in),
        .cin   (cin_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_in),
`endif
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .co    (co4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic ci, input logic sb);
        if (sb) return {1'b0, a} + {1'b0, ~b} + 9'd1;
        return {1'b0, a} + {1'b0, b} + {8'd0, ci};
    endfunction

    // Monitors: compare every done pulse against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            check("dut1_done_pending", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("dut1_sum", 32'(sum1), 32'(e.sum));
                check("dut1_co", 32'(co1), 32'(e.co));
                check("dut1_latency", 32'(cyc - e.issue), 32'd8);
                held1 = e.sum;
            end
            check("dut1_done_single", 32'(prev1), 32'd0);
        end
        prev1 = done1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            check("dut4_done_pending", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) begin
                e = q4.pop_front();
                check("dut4_sum", 32'(sum4), 32'(e.sum));
                check("dut4_co", 32'(co4), 32'(e.co));
                check("dut4_latency", 32'(cyc - e.issue), 32'd2);
                held4 = e.sum;
            end
            check("dut4_done_single", 32'(prev4), 32'd0);
        end
        prev4 = done4;
    end

    // Issue one operation from a negedge with the selected DUT idle or in DONE.
    // Returns at the negedge of the DONE cycle. mid=1 pulses a stray start
    // with A=0xAA while the operation is running.
    task automatic op(input int sel, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic sb, input logic [7:0] es,
                      input logic ec, input bit mid);
        exp_t e;
        int   n;
        n      = (sel != 0) ? 2 : 8;
        a_in   = a;
        b_in   = b;
        cin_in = ci;
        sub_in = sb;
        if (sel != 0) start4 = 1'b1;
        else          start1 = 1'b1;
        e.sum   = es;
        e.co    = ec;
        e.issue = cyc + 1;
        if (sel != 0) q4.push_back(e);
        else          q1.push_back(e);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            start4 = 1'b0;
            if (k == 0) begin
                a_in   = 8'($urandom);
                b_in   = 8'($urandom);
                cin_in = 1'($urandom);
            end
            if (mid && k == 2) begin
                a_in = 8'hAA;
                if (sel != 0) start4 = 1'b1;
                else          start1 = 1'b1;
            end
            check("run_busy", 32'((sel != 0) ? busy4 : busy1), 32'd1);
            check("run_sum_held", 32'((sel != 0) ? sum4 : sum1),
                  32'((sel != 0) ? held4 : held1));
        end
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        check("done_busy_low", 32'((sel != 0) ? busy4 : busy1), 32'd0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc, rs;
        logic [8:0] r;

        // Reset state.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_sum1", 32'(sum1), 32'd0);
        check("rst_co1", 32'(co1), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_sum4", 32'(sum4), 32'd0);
        @(negedge clk);

        // Bit-serial directed vectors.
        op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0);
        @(negedge clk);
        op(0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        // Start in the DONE cycle is accepted.
        op(0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        // Stray start while busy is ignored.
        op(0, 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b1);
        @(negedge clk);

        // DIGIT=4 directed vectors.
        op(1, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        op(1, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        @(negedge clk);
        op(1, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);

        // Reset after step 3 of 8 aborts with no done pulse.
        a_in   = 8'h77;
        b_in   = 8'h11;
        cin_in = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        held1 = 8'h00;
        held4 = 8'h00;
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_sum", 32'(sum1), 32'd0);
        check("abort_co", 32'(co1), 32'd0);
        check("abort_sum4", 32'(sum4), 32'd0);
        repeat (10) @(negedge clk);
        check("abort_no_done", 32'(q1.size()), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
        // Subtract: cin is ignored when sub=1.
        op(0, 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0);
        @(negedge clk);
        op(0, 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        op(1, 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
        @(negedge clk);
`endif

        // Random operands against the reference model, mixing idle gaps and
        // back-to-back starts.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 40; i++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
                rs = 1'($urandom);
`else
                rs = 1'b0;
`endif
                r = model(ra, rb, rc, rs);
                op(s, ra, rb, rc, rs, r[7:0], r[8], 1'b0);
                if ($urandom_range(0, 1) != 0) @(negedge clk);
            end
            @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("dut1_queue_drained", 32'(q1.size()), 32'd0);
        check("dut4_queue_drained", 32'(q4.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised digit-serial multi-cycle adder that generalises the single-bit full adder to WIDTH-bit operands. It processes DIGIT bits per clock through a registered carry, using a start/busy/done handshake. Results are held until the next operation. It is used where a wide ripple adder is too costly and a multi-cycle latency is acceptable.

Parameters:
WIDTH, 8, operand and sum width in bits; must be an exact multiple of DIGIT.
DIGIT, 1, bits added per clock cycle; 1 gives a pure bit-serial adder, DIGIT=WIDTH gives a single-digit adder.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request a new addition; sampled only when not busy
A  input  WIDTH  operand A; captured on an accepted start
B  input  WIDTH  operand B; captured on an accepted start
cin  input  1  carry-in; captured on an accepted start
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse when sum/co are updated
sum  output  WIDTH  registered result A+B+cin (low WIDTH bits)
co  output  1  registered carry-out of the full WIDTH-bit addition

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high.
- N = WIDTH/DIGIT digit steps per operation. Internal elements: operand shift registers, a result shift register, a carry flop, and a step counter of width clog2(N+1).
- Reset, taking effect at the clk edge where rst=1: state=IDLE, busy=0, done=0, sum=0, co=0, carry=0, counter=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge 0 latches A, B, cin into the operand registers and carry. Sets counter=0 and busy=1, then moves to RUN. start=0 keeps the block in IDLE.
- RUN: at each edge k (k=1..N), compute {c, d} = A_sh[DIGIT-1:0] + B_sh[DIGIT-1:0] + carry.
  - d is shifted into the MSB end of the result register (right shift by DIGIT).
  - The operand registers are right-shifted by DIGIT.
  - carry <= c; counter increments.
- At edge N: sum <= final result register, co <= final carry, done <= 1, busy <= 0, then move to DONE.
- Latency: done is high in the cycle following edge N, i.e. N cycles after the start sample. The next start is accepted no earlier than edge N+1.
- DONE: lasts exactly one cycle, after which done returns to 0. It behaves like IDLE, so start=1 in this cycle is accepted and moves to RUN with busy=1.
- sum and co change only at completion. They hold their previous values throughout RUN and IDLE.
- start while busy=1 is ignored, with no effect on operands or timing. Input changes during RUN are ignored.
- Arithmetic: result is modulo 2^WIDTH, and co is bit WIDTH of the WIDTH+1-bit exact sum. This matches the equation {co,sum} = A+B+cin for any WIDTH/DIGIT.
- Reset mid-operation aborts the addition. No done pulse is produced, and sum/co return to 0.
- rst has priority over start on the same edge.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- When defined: an extra input port sub (1 bit) is added after cin and is captured on an accepted start.
  - sub=1 computes A + ~B + 1 (two's-complement A-B); cin is ignored, and the carry register is initialised to 1 with B inverted at capture.
  - co=1 means no borrow (A>=B unsigned).
  - sub=0 gives the normal addition.
- When undefined: no sub port and addition only; behaviour and timing are otherwise identical.

Test Plan:
1. WIDTH=8, DIGIT=1: reset, then start with A=0x5A, B=0x3C, cin=0. Expect busy=1 for 8 cycles, then done pulse; sum=0x96, co=0.
2. WIDTH=8, DIGIT=1: A=0xFF, B=0x00, cin=1. Expect sum=0x00, co=1. Next, start asserted in the DONE cycle with A=0x01, B=0x01, cin=0 is accepted; expect sum=0x02, co=0 8 cycles later.
3. WIDTH=8, DIGIT=4: A=0xFF, B=0xFF, cin=1. Expect done after 2 cycles with sum=0xFF, co=1.
4. Start A=0x10, B=0x20; pulse start again with A=0xAA mid-RUN. Expect the second start ignored, result sum=0x30. Separately, assert rst at step 3 of 8: expect no done pulse, sum=0, co=0, busy=0.
5. With SERIAL_ADDER_SUB_EN, sub=1: A=0x10, B=0x01 expects sum=0x0F, co=1; A=0x01, B=0x02 expects sum=0xFF, co=0.
6. Random regression over 1000 operands for WIDTH in {8, 16} and DIGIT in {1, 2, 4, WIDTH}. Compare {co,sum} against the reference model A+B+cin and check the N-cycle latency on each operation.
